// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
//  Module      : mips_ctrl_pkg
//  Description : Shared encodings, the pipelined control-word type and the
//                bubble constant for the hazard/control pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

    // ALU operation encodings driven by the ID decoder
    localparam logic [2:0] c_ALUOP_ADD   = 3'b000;
    localparam logic [2:0] c_ALUOP_SUB   = 3'b001;
    localparam logic [2:0] c_ALUOP_OR    = 3'b010;
    localparam logic [2:0] c_ALUOP_AND   = 3'b011;
    localparam logic [2:0] c_ALUOP_RTYPE = 3'b100;

    // Load width / sign-extension modes
    localparam logic [1:0] c_LDM_WORD    = 2'b00;
    localparam logic [1:0] c_LDM_HALF_S  = 2'b01;
    localparam logic [1:0] c_LDM_HALF_U  = 2'b10;

    // Primary opcodes of the instructions this pipeline distinguishes
    localparam logic [5:0] c_OP_RTYPE    = 6'h00;
    localparam logic [5:0] c_OP_BEQ      = 6'h04;
    localparam logic [5:0] c_OP_ADDI     = 6'h08;
    localparam logic [5:0] c_OP_LW       = 6'h23;
    localparam logic [5:0] c_OP_SW       = 6'h2B;

    // Control word carried down the pipe. RegDst is consumed in ID (it picks
    // the destination register) so it is not part of the stored word.
    typedef struct packed {
        logic       RegWrite;
        logic       MemToReg;
        logic       MemWrite;
        logic       MemRead;
        logic       Branch;
        logic [1:0] load_mode;
        logic       ALUSrc;
        logic [2:0] ALUOp;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_BUBBLE = '0;

    // R-type (RegDst), BEQ (Branch) and SW (MemWrite) read rt as a source
    function automatic logic uses_rt(input logic reg_dst,
                                     input logic branch,
                                     input logic mem_write);
        return reg_dst | branch | mem_write;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_stage_reg.sv
// ============================================================================
//  Module      : ctrl_stage_reg
//  Description : One pipeline control register (control word + destination
//                register) with async reset and a synchronous bubble load.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_stage_reg
    import mips_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bubble,
    input  ctrl_word_t        ctrl_d,
    input  logic [REG_AW-1:0] dest_d,
    output ctrl_word_t        ctrl_q,
    output logic [REG_AW-1:0] dest_q
);

    // Advance one stage per clock; a bubble request replaces the incoming word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= CTRL_BUBBLE;
            dest_q <= '0;
        end else if (bubble) begin
            ctrl_q <= CTRL_BUBBLE;
            dest_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            dest_q <= dest_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ctrl_pipe_hazard_unit.sv
// ============================================================================
//  Module      : ctrl_pipe_hazard_unit
//  Description : Carries decoder controls through EX/MEM/WB, stalls one cycle
//                on load-use hazards and flushes younger instructions when a
//                branch resolves taken in MEM.
//                Optional macro CTRL_PERF_CNT_EN adds stall/flush counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_pipe_hazard_unit
    import mips_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int STALL_CW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              RegDst,
    input  logic              RegWrite,
    input  logic              ALUSrc,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic              MemToReg,
    input  logic              Branch,
    input  logic [2:0]        ALUOp,
    input  logic [1:0]        load_mode,
    input  logic              branch_taken,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              ex_ALUSrc,
    output logic [2:0]        ex_ALUOp,
    output logic [REG_AW-1:0] ex_dest,
    output logic              mem_MemWrite,
    output logic              mem_MemRead,
    output logic              mem_Branch,
    output logic [1:0]        mem_load_mode,
    output logic              wb_RegWrite,
    output logic              wb_MemToReg,
    output logic [REG_AW-1:0] wb_dest
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [STALL_CW-1:0] stall_cnt,
    output logic [STALL_CW-1:0] flush_cnt
`endif
);

    ctrl_word_t        w_id_ctrl;
    logic [REG_AW-1:0] w_id_dest;
    ctrl_word_t        w_ex_ctrl;
    ctrl_word_t        w_mem_ctrl;
    ctrl_word_t        w_wb_ctrl;
    logic [REG_AW-1:0] w_mem_dest;
    logic [REG_AW-1:0] r_ex_rt;
    logic              w_load_use;
    logic              w_flush;
    logic              w_stall;

    // Pack decoder controls; an invalid ID slot becomes an all-zero bubble
    always_comb begin
        w_id_ctrl = CTRL_BUBBLE;
        w_id_dest = '0;
        if (id_valid) begin
            w_id_ctrl.RegWrite  = RegWrite;
            w_id_ctrl.MemToReg  = MemToReg;
            w_id_ctrl.MemWrite  = MemWrite;
            w_id_ctrl.MemRead   = MemRead;
            w_id_ctrl.Branch    = Branch;
            w_id_ctrl.load_mode = load_mode;
            w_id_ctrl.ALUSrc    = ALUSrc;
            w_id_ctrl.ALUOp     = ALUOp;
            w_id_dest           = RegDst ? id_rd : id_rt;
        end
    end

    // Load-use detection and branch flush; a flush overrides a stall because
    // the stalled instruction is being discarded anyway
    always_comb begin
        w_load_use = w_ex_ctrl.MemRead && (r_ex_rt != '0) &&
                     ((r_ex_rt == id_rs) ||
                      ((r_ex_rt == id_rt) && uses_rt(RegDst, Branch, MemWrite)));
        w_flush    = w_mem_ctrl.Branch & branch_taken;
        w_stall    = w_load_use & ~w_flush;
        pc_write   = ~w_stall;
        ifid_write = ~w_stall;
        ifid_flush = w_flush;
    end

    // rt of the instruction in EX; only meaningful while that instruction is a
    // load, and a bubble clears MemRead so a stale value is harmless
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_rt <= '0;
        end else begin
            r_ex_rt <= id_rt;
        end
    end

    ctrl_stage_reg #(.REG_AW(REG_AW)) u_id_ex (
        .clk    (clk),
        .rst    (rst),
        .bubble (w_stall | w_flush),
        .ctrl_d (w_id_ctrl),
        .dest_d (w_id_dest),
        .ctrl_q (w_ex_ctrl),
        .dest_q (ex_dest)
    );

    ctrl_stage_reg #(.REG_AW(REG_AW)) u_ex_mem (
        .clk    (clk),
        .rst    (rst),
        .bubble (w_flush),
        .ctrl_d (w_ex_ctrl),
        .dest_d (ex_dest),
        .ctrl_q (w_mem_ctrl),
        .dest_q (w_mem_dest)
    );

    // The resolving branch itself always retires into WB
    ctrl_stage_reg #(.REG_AW(REG_AW)) u_mem_wb (
        .clk    (clk),
        .rst    (rst),
        .bubble (1'b0),
        .ctrl_d (w_mem_ctrl),
        .dest_d (w_mem_dest),
        .ctrl_q (w_wb_ctrl),
        .dest_q (wb_dest)
    );

    assign ex_ALUSrc     = w_ex_ctrl.ALUSrc;
    assign ex_ALUOp      = w_ex_ctrl.ALUOp;
    assign mem_MemWrite  = w_mem_ctrl.MemWrite;
    assign mem_MemRead   = w_mem_ctrl.MemRead;
    assign mem_Branch    = w_mem_ctrl.Branch;
    assign mem_load_mode = w_mem_ctrl.load_mode;
    assign wb_RegWrite   = w_wb_ctrl.RegWrite;
    assign wb_MemToReg   = w_wb_ctrl.MemToReg;

`ifdef CTRL_PERF_CNT_EN
    // Free-running wrap-around event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (w_stall) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (w_flush) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
